// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage core.
// Holds fetch FSM states and the IF/ID bundle used by fetch and decode.
package rv_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register with bubble, load and hold controls.
// Bubble takes priority over load; neither asserted holds the contents.
module ifid_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    // Bundle register: reset and bubble both insert a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ifid_bubble(NOP);
        end else if (bubble) begin
            q <= ifid_bubble(NOP);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and IF/ID capture.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          IMEM_WORDS    = 73,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
    parameter int          HALT_ON_ECALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic        fetch_fault_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    import rv_pipe_pkg::*;

    localparam logic [29:0] WORD_LIM = 30'(IMEM_WORDS);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_next4;
    logic [31:0]  tgt_pc;
    logic         fault_q;
    logic         halted_q;
    logic         in_range;
    logic         is_ecall;
    logic         ifid_load;
    logic         ifid_bub;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    assign pc_next4 = pc_q + 32'd4;
    assign tgt_pc   = redirect_pc_i & ~32'h0000_0003;
    assign in_range = pc_q[31:2] < WORD_LIM;
    assign is_ecall = (HALT_ON_ECALL != 0)
                    && (imem_instr_i == ECALL_INSTR);

    assign ifid_d = '{pc:    pc_q,
                      pc4:   pc_next4,
                      instr: imem_instr_i,
                      valid: 1'b1};

    // IF/ID control: redirect > stall > fault > capture
    always_comb begin
        ifid_load = 1'b0;
        ifid_bub  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect_i) begin
                    ifid_bub = 1'b1;
                end else if (!stall_i) begin
                    if (in_range) ifid_load = 1'b1;
                    else          ifid_bub  = 1'b1;
                end
            end
            HALT: begin
                if (redirect_i || !stall_i) ifid_bub = 1'b1;
            end
            default: begin
                ifid_load = 1'b0;
                ifid_bub  = 1'b0;
            end
        endcase
    end

    ifid_reg #(
        .NOP (NOP_INSTR)
    ) u_ifid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .bubble (ifid_bub),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    // Fetch FSM with PC, halt flag and sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (redirect_i) begin
                        pc_q <= tgt_pc;
                    end else if (stall_i) begin
                        pc_q <= pc_q;
                    end else if (!in_range) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        pc_q <= pc_next4;
                        if (is_ecall) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    end
                end
                HALT: begin
                    if (redirect_i) begin
                        pc_q     <= tgt_pc;
                        fault_q  <= 1'b0;
                        halted_q <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_fetch_q;
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_flush_q;
    logic        active;

    assign active = (state_q != BOOT);

    // Saturating event counters, idle during BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fetch_q <= '0;
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            if (ifid_load && cnt_fetch_q != '1)
                cnt_fetch_q <= cnt_fetch_q + 32'd1;
            if (active && stall_i && cnt_stall_q != '1)
                cnt_stall_q <= cnt_stall_q + 32'd1;
            if (active && redirect_i && cnt_flush_q != '1)
                cnt_flush_q <= cnt_flush_q + 32'd1;
        end
    end

    assign perf_fetched_o = cnt_fetch_q;
    assign perf_stall_o   = cnt_stall_q;
    assign perf_flush_o   = cnt_flush_q;
`endif

    assign imem_pc_o     = pc_q;
    assign ifid_pc_o     = ifid_q.pc;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_instr_o  = ifid_q.instr;
    assign ifid_valid_o  = ifid_q.valid;
    assign halted_o      = halted_q;
    assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised and directed bench for if_fetch_stage.
// Reference model tracks fetch at the transaction level.
module tb_if_fetch_stage;

    localparam int          WORDS = 73;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [WORDS];

    // model state: mode 0 = booting, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_halt;
    logic        m_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if ((a >> 2) < 32'(WORDS)) return mem[idx];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = rd(imem_pc);

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_pc_o     (imem_pc),
        .imem_instr_i  (imem_instr),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .ifid_valid_o  (ifid_valid),
        .halted_o      (halted),
        .fetch_fault_o (fault)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_bubble();
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    // one clock of fetch behaviour with the current inputs
    task automatic model_edge();
        logic [31:0] w;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            model_bubble();
            m_mode  = 1;
            m_halt  = 1'b0;
            m_fault = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_mode == 2) begin
            model_bubble();
        end else if ((m_pc >> 2) >= 32'(WORDS)) begin
            model_bubble();
            m_fault = 1'b1;
            m_halt  = 1'b1;
            m_mode  = 2;
        end else begin
            w       = rd(m_pc);
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = w;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (w == ECALL) begin
                m_halt = 1'b1;
                m_mode = 2;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_pc", imem_pc, m_pc);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_pc4", ifid_pc4, m_ipc4);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    // drive inputs for the next edge, then compare after it
    task automatic tick(input logic st, input logic rdr,
                        input logic [31:0] tgt);
        stall       = st;
        redirect    = rdr;
        redirect_pc = tgt;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++)
            mem[i] = {16'hC0DE, 8'(i), 8'h33};
        mem[4] = ECALL;
        model_reset();

        repeat (2) @(negedge clk);
        check_all();
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        rst_n = 1'b1;

        tick(1'b0, 1'b0, 32'h0);
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        chk("boot_pc", imem_pc, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("f0_pc", ifid_pc, 32'h0);
        chk("f0_instr", ifid_instr, 32'hC0DE_0033);
        chk("f0_valid", 32'(ifid_valid), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        chk("f1_pc", ifid_pc, 32'h4);
        tick(1'b0, 1'b0, 32'h0);
        chk("f2_pc", ifid_pc, 32'h8);

        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("stall_ifid", ifid_pc, 32'h8);
        chk("stall_imem", imem_pc, 32'hC);
        tick(1'b0, 1'b0, 32'h0);
        chk("resume_pc", ifid_pc, 32'hC);

        tick(1'b1, 1'b1, 32'h0000_0042);
        chk("redir_valid", 32'(ifid_valid), 32'd0);
        chk("redir_nop", ifid_instr, NOP);
        chk("redir_imem", imem_pc, 32'h40);
        tick(1'b0, 1'b0, 32'h0);
        chk("redir_pc", ifid_pc, 32'h40);

        tick(1'b0, 1'b1, 32'h10);
        tick(1'b0, 1'b0, 32'h0);
        chk("ecall_pc", ifid_pc, 32'h10);
        chk("ecall_instr", ifid_instr, ECALL);
        chk("ecall_valid", 32'(ifid_valid), 32'd1);
        chk("ecall_halt", 32'(halted), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        chk("halt_imem", imem_pc, 32'h14);
        chk("halt_bub", 32'(ifid_valid), 32'd0);
        tick(1'b0, 1'b1, 32'h8);
        chk("unhalt", 32'(halted), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        chk("refetch8", ifid_pc, 32'h8);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h14);

        for (int i = 0; i < 100 && !fault; i++)
            tick(1'b0, 1'b0, 32'h0);
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_halt", 32'(halted), 32'd1);
        chk("fault_imem", imem_pc, 32'd292);
        chk("fault_bub", 32'(ifid_valid), 32'd0);
        tick(1'b0, 1'b1, 32'h0);
        chk("fault_clr", 32'(fault), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        chk("resume0", ifid_pc, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("pre_rst", 32'(ifid_valid), 32'd1);

        async_reset();
        chk("arst_valid", 32'(ifid_valid), 32'd0);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_imem", imem_pc, 32'h0);

        mem[40] = ECALL;
        for (int n = 0; n < 3000; n++) begin
            logic        st;
            logic        rr;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 9) == 0);
            tg = 32'($urandom_range(0, 90) * 4)
               + 32'($urandom_range(0, 3));
            tick(st, rr, tg);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
